// File: rtl/muldiv_multicycle.sv
// muldiv_multicycle: radix-2 iterative RV32M multiply/divide unit.
// One product or quotient bit per clock behind a start/busy/done handshake.
module muldiv_multicycle #(
  parameter int DATA_W    = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [4:0]        iControl,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oResult
);

  // Same encoding as the ALU control field.
  localparam logic [4:0] OPMUL    = 5'd8;
  localparam logic [4:0] OPMULH   = 5'd9;
  localparam logic [4:0] OPMULHSU = 5'd10;
  localparam logic [4:0] OPMULHU  = 5'd11;
  localparam logic [4:0] OPDIV    = 5'd12;
  localparam logic [4:0] OPDIVU   = 5'd13;
  localparam logic [4:0] OPREM    = 5'd14;
  localparam logic [4:0] OPREMU   = 5'd15;

  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state;
  state_t state_nx;

  // Latched operation context
  logic [4:0]        op_q;
  logic              mul_q;
  logic              neg_q;
  logic              neg_r;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] res;

  // Accept-time decode
  logic              valid;
  logic              is_mul;
  logic              is_quo;
  logic              a_sgd;
  logic              b_sgd;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              bzero;
  logic              ovf;
  logic              early;
  logic [DATA_W-1:0] early_res;
  logic              accept;

  // Iteration datapath
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     rsh;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   hi_nx;
  logic [DATA_W-1:0]   lo_nx;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   fin;

  assign accept = iStart && (state != CALC);

  // Opcode decode: kind and operand signedness
  always_comb begin
    valid  = 1'b1;
    is_mul = 1'b0;
    is_quo = 1'b0;
    a_sgd  = 1'b0;
    b_sgd  = 1'b0;
    unique case (iControl)
      OPMUL:    begin is_mul = 1'b1; a_sgd = 1'b1; b_sgd = 1'b1; end
      OPMULH:   begin is_mul = 1'b1; a_sgd = 1'b1; b_sgd = 1'b1; end
      OPMULHSU: begin is_mul = 1'b1; a_sgd = 1'b1; end
      OPMULHU:  begin is_mul = 1'b1; end
      OPDIV:    begin is_quo = 1'b1; a_sgd = 1'b1; b_sgd = 1'b1; end
      OPDIVU:   begin is_quo = 1'b1; end
      OPREM:    begin a_sgd = 1'b1; b_sgd = 1'b1; end
      OPREMU:   begin end
      default:  valid = 1'b0;
    endcase
  end

  assign a_neg = a_sgd && iA[DATA_W-1];
  assign b_neg = b_sgd && iB[DATA_W-1];
  assign a_mag = a_neg ? -iA : iA;
  assign b_mag = b_neg ? -iB : iB;
  assign bzero = (iB == ZERO);
  assign ovf   = a_sgd && b_sgd && (iA == SMIN) && (&iB);

  assign early = EARLY_OUT &&
                 (!valid || (!is_mul && (bzero || ovf)));

  // Direct results for cases that skip the iteration
  always_comb begin
    early_res = ZERO;
    if (!valid)
      early_res = ZERO;
    else if (bzero)
      early_res = is_quo ? '1 : iA;
    else if (ovf)
      early_res = is_quo ? SMIN : ZERO;
  end

  // One shift-add or restoring-subtract step
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    rsh   = {hi, lo[DATA_W-1]};
    diff  = rsh - {1'b0, dvs};
    hi_nx = hi;
    lo_nx = lo;
    if (mul_q) begin
      hi_nx = sum[DATA_W:1];
      lo_nx = {sum[0], lo[DATA_W-1:1]};
    end else if (!diff[DATA_W]) begin
      hi_nx = diff[DATA_W-1:0];
      lo_nx = {lo[DATA_W-2:0], 1'b1};
    end else begin
      hi_nx = rsh[DATA_W-1:0];
      lo_nx = {lo[DATA_W-2:0], 1'b0};
    end
  end

  // Sign fix-up and result select after the last step
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_nx : lo_nx;
    rem    = neg_r ? -hi_nx : hi_nx;
    unique case (op_q)
      OPMUL:    fin = prod_s[DATA_W-1:0];
      OPMULH:   fin = prod_s[2*DATA_W-1:DATA_W];
      OPMULHSU: fin = prod_s[2*DATA_W-1:DATA_W];
      OPMULHU:  fin = prod_s[2*DATA_W-1:DATA_W];
      OPDIV:    fin = quo;
      OPDIVU:   fin = quo;
      OPREM:    fin = rem;
      OPREMU:   fin = rem;
      default:  fin = ZERO;
    endcase
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (iStart) state_nx = early ? DONE : CALC;
      CALC: if (cnt == LAST) state_nx = DONE;
      DONE: begin
        if (iStart) state_nx = early ? DONE : CALC;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    oBusy = (state == CALC);
    oDone = (state == DONE);
  end

  assign oResult = res;

  // Operand latch, iteration registers and result
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      op_q  <= '0;
      mul_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvs   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      res   <= ZERO;
    end else if (accept) begin
      op_q  <= iControl;
      mul_q <= is_mul;
      neg_q <= (a_neg ^ b_neg) && !(!is_mul && bzero);
      neg_r <= a_neg;
      dvs   <= is_mul ? a_mag : b_mag;
      hi    <= '0;
      lo    <= is_mul ? b_mag : a_mag;
      cnt   <= '0;
      if (early) res <= early_res;
    end else if (state == CALC) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) res <= fin;
    end
  end

endmodule

// File: doc/muldiv_multicycle.md
Name: muldiv_multicycle

Overview:
- Iterative multi-cycle unit for the RV32M operations: MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM and REMU.
- Sits beside the ALU in the multicycle/pipelined datapath. The control path issues an operation with a start/busy/done handshake instead of paying the combinational multiply/divide delay.
- Uses the same 5-bit operation encoding (OPMUL..OPREMU, ZERO) from Parametros.v as the ALU's iControl input.
- Radix-2: one partial-product or quotient bit per clock.

Parameters:
- DATA_W, 32: operand/result width. Only 32 is supported; the iteration counter is sized to count DATA_W cycles.
- EARLY_OUT, 1: if 1, divide-by-zero, signed overflow and unsupported opcodes complete in 1 cycle instead of DATA_W.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset. Synchronous, active-high, one clock domain.
- iStart  in  1  request. Sampled only when oBusy=0.
- iControl  in  5  operation code (OPMUL..OPREMU). Latched at accept.
- iA  in  32  operand A (rs1). Latched at accept.
- iB  in  32  operand B (rs2). Latched at accept.
- oBusy  out  1  high while an operation is in progress.
- oDone  out  1  one-cycle pulse; oResult is valid in this cycle.
- oResult  out  32  result. Held stable from oDone until the next accept.

Behaviour:
- Reset: state=IDLE, oBusy=0, oDone=0, oResult=ZERO, internal registers cleared.
  - iRST mid-operation aborts immediately.
  - No oDone is produced for the aborted operation.
- States:
  - IDLE: oBusy=0. On iStart=1, latch operands and opcode, then go to CALC (or to DONE on an early-out case).
  - CALC: oBusy=1. Count 0..DATA_W-1 and perform one iteration per cycle. After the iteration with count=DATA_W-1, go to DONE.
  - DONE: oBusy=0, oDone=1, oResult written.
    - If iStart=1 in this cycle, accept the new operation (back-to-back).
    - Otherwise go to IDLE.
- Latency:
  - Normal case: accept at edge t, oDone high in cycle t+33 (32 CALC cycles plus DONE).
  - Early-out case: oDone high in cycle t+1.
- Handshake rules:
  - iStart while oBusy=1 is ignored; no queueing.
  - Changes on iA, iB or iControl after accept have no effect.
- Multiply:
  - Shift-add on the operand magnitudes, producing a 64-bit product.
  - Product is negated when the signs differ.
  - Signedness per opcode: MUL and MULH treat A and B as signed; MULHU treats both as unsigned; MULHSU treats A as signed and B as unsigned.
  - Output: MUL returns P[31:0]; MULH, MULHU and MULHSU return P[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(A) XOR sign(B), signed ops only.
  - Remainder takes the sign of the dividend.
- Special cases (RISC-V spec):
  - DIV or DIVU with B=0: quotient=0xFFFFFFFF.
  - REM or REMU with B=0: remainder=A.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000.
  - REM with 0x80000000 / 0xFFFFFFFF: result 0.
  - With EARLY_OUT=1 these cases take 1 cycle; with EARLY_OUT=0 they take 32 cycles with the same results.
- Unsupported opcode (anything other than the 8 M-extension codes): oResult=ZERO, completes as early-out.
- Zero operands: results must be exact, e.g. MUL 0*x=0 and DIV 0/x=0.

Test Plan:
- Multiply:
  - Stimulus: MUL with A=7, B=0xFFFFFFFD (-3); start at cycle 0.
  - Response: oBusy high for cycles 1-32; oDone and oResult=0xFFFFFFEB at cycle 33; oResult held afterwards.
- High-half products:
  - MULH with A=B=0x80000000 -> 0x40000000.
  - MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- Signed divide:
  - DIV with A=-7, B=2 -> 0xFFFFFFFD.
  - REM with A=-7, B=2 -> 0xFFFFFFFF.
  - DIVU with A=100, B=7 -> 14.
  - REMU with A=100, B=7 -> 2.
- Corner cases with EARLY_OUT=1:
  - DIVU with A=5, B=0 -> 0xFFFFFFFF, oDone at cycle 1.
  - REM with A=5, B=0 -> 5.
  - DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - Assert iStart with new operands at cycle 5 of a running MUL. It is ignored and the original result is returned.
  - iStart in the DONE cycle is accepted; the second result arrives 33 cycles later.
- Reset:
  - Assert iRST at CALC cycle 10.
  - Next cycle: oBusy=0, oResult=0, and no oDone ever arrives for the aborted operation.
  - A fresh DIVU with A=9, B=3 then returns 3 normally.
